id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
Pipeline register and operand-select stage directly upstream of the ALU. Captures decoded register-format and immediate instructions from decode and holds one entry with valid/ready handshakes on both sides. Resolves EX/MEM and MEM/WB forwarding hazards and drives the ALU operands (alu_in1, alu_in2) and the 6-bit function code (alu_con).

Parameters:
DW, 32, datapath width
AW, 5, register address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
flush  input  1  synchronous; kill held and incoming entry
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
rs_data  input  DW  register file read, rs
rt_data  input  DW  register file read, rt
rs_addr  input  AW  source register rs
rt_addr  input  AW  source register rt
rd_addr  input  AW  destination register
shamt  input  5  shift amount field
funct  input  6  ALU function code
imm  input  16  immediate field
use_imm  input  1  1: operand 2 is sign-extended imm
reg_write  input  1  instruction writes rd
exmem_reg_write  input  1  EX/MEM stage writes
exmem_rd  input  AW  EX/MEM destination
exmem_result  input  DW  EX/MEM value
memwb_reg_write  input  1  MEM/WB stage writes
memwb_rd  input  AW  MEM/WB destination
memwb_result  input  DW  MEM/WB value
out_valid  output  1  held entry valid to ALU stage
out_ready  input  1  ALU stage consumes this cycle
alu_in1  output  DW  ALU operand 1
alu_in2  output  DW  ALU operand 2
alu_con  output  6  ALU function code
ex_rd  output  AW  destination, passed along
ex_reg_write  output  1  write enable, passed along (gated by out_valid)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset: out_valid=0. All held registers are 0, so alu_in1=0, alu_in2=0, alu_con=6'b000000, ex_rd=0, ex_reg_write=0.
- Input acceptance: in_ready = !out_valid || out_ready (combinational).
- Transfer on the input side: when in_valid && in_ready, the entry is captured at the edge and out_valid=1 next cycle.
- Latency: one cycle from acceptance to presentation. Back-to-back throughput is one entry per cycle when out_ready is held at 1.
- Consume without replacement: out_valid && out_ready with no new accept gives out_valid=0 next cycle.
- Capture: the stage latches op_a, op_b, rs_addr, rt_addr, rd_addr, funct and reg_write.
  - Shift-immediate funct 000000, 000010, 000011: op_a = zero-extended shamt.
  - Variable shift funct 000100, 000110: op_a = rs_data.
  - All other funct values: op_a = rs_data.
  - use_imm=1: op_b = sign-extended imm. use_imm=0: op_b = rt_data.
  - A src_a_is_reg bit is stored with the entry (0 for shift-immediate). A src_b_is_reg bit is stored as !use_imm.
- Forwarding (combinational on outputs): register 0 is never forwarded.
  - alu_in1 = exmem_result if src_a_is_reg && exmem_reg_write && exmem_rd==rs && rs!=0.
  - Otherwise alu_in1 = memwb_result under the same match rule against memwb_rd.
  - Otherwise alu_in1 = op_a.
  - When both EX/MEM and MEM/WB match, EX/MEM has priority.
  - alu_in2 uses the same rules against rt and src_b_is_reg.
- Operand refresh while held: on each edge where out_valid && !out_ready, op_a and op_b are overwritten with the current forwarded alu_in1 and alu_in2. A forwarded value therefore survives after its producer retires.
- Capture-cycle forwarding: rs_data and rt_data are taken as given. Decode-side bypass belongs to the register file.
- Outputs to the ALU: alu_con = latched funct. ex_reg_write = reg_write && out_valid.
- flush: the next state is out_valid=0 and ex_reg_write=0. flush overrides a simultaneous accept, and the incoming entry is dropped. in_ready is not affected by flush.
- reset has priority over flush and over any handshake, including mid-hold.
- Wrap-around: sign extension of imm 0x8000 gives 0xFFFF8000. Shamt 31 gives 0x0000001F. No arithmetic is done in this stage.

Test Plan:
- Reset then accept rs=R1(0x5), rt=R2(0x3), funct=100000, out_ready=1 -> next cycle out_valid=1, alu_in1=5, alu_in2=3, alu_con=100000; following cycle out_valid=0.
- Held entry rs=R4 with out_ready=0; EX/MEM rd=4 writes 0xAA for one cycle, then leaves -> alu_in1=0xAA while matched and remains 0xAA afterwards; in_ready=0 throughout the hold.
- EX/MEM and MEM/WB both target rt=R7 (0x11 vs 0x22); also rd=0 writes with rs=R0 -> alu_in2=0x11; R0 never forwarded, alu_in1=op_a.
- funct=000000, shamt=3, rt=0x5 -> alu_in1=3, alu_in2=5. use_imm=1, imm=0xFFFE -> alu_in2=0xFFFFFFFE.
- Back-to-back accepts with out_ready=1 for 4 cycles -> one entry per cycle, no bubbles. out_ready=0 with in_valid=1 -> in_ready=0 and entry held unchanged.
- flush asserted together with in_valid -> out_valid=0 and ex_reg_write=0 next cycle. reset asserted mid-hold -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// id_ex_operand_stage: one-entry ID/EX register with EX/MEM, MEM/WB forwarding
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic          use_imm,
  input  logic          reg_write,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [5:0]    alu_con,
  output logic [AW-1:0] ex_rd,
  output logic          ex_reg_write
);

  logic          valid_q,     valid_d;
  logic [DW-1:0] op_a_q,      op_a_d;
  logic [DW-1:0] op_b_q,      op_b_d;
  logic [AW-1:0] rs_q,        rs_d;
  logic [AW-1:0] rt_q,        rt_d;
  logic [AW-1:0] rd_q,        rd_d;
  logic [5:0]    funct_q,     funct_d;
  logic          reg_write_q, reg_write_d;
  logic          src_a_reg_q, src_a_reg_d;
  logic          src_b_reg_q, src_b_reg_d;

  logic          w_accept;
  logic          w_shift_imm;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never bypassed.
  function automatic logic [DW-1:0] fwd(
    input logic          is_reg,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] own,
    input logic          em_we,
    input logic [AW-1:0] em_rd,
    input logic [DW-1:0] em_val,
    input logic          mw_we,
    input logic [AW-1:0] mw_rd,
    input logic [DW-1:0] mw_val
  );
    logic [DW-1:0] r;
    r = own;
    if (is_reg && (addr != '0)) begin
      if (em_we && (em_rd == addr))      r = em_val;
      else if (mw_we && (mw_rd == addr)) r = mw_val;
    end
    return r;
  endfunction

  assign alu_in1 = fwd(src_a_reg_q, rs_q, op_a_q, exmem_reg_write, exmem_rd,
                       exmem_result, memwb_reg_write, memwb_rd, memwb_result);
  assign alu_in2 = fwd(src_b_reg_q, rt_q, op_b_q, exmem_reg_write, exmem_rd,
                       exmem_result, memwb_reg_write, memwb_rd, memwb_result);

  assign in_ready     = !valid_q || out_ready;
  assign out_valid    = valid_q;
  assign alu_con      = funct_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q && valid_q;

  assign w_accept    = in_valid && in_ready;
  assign w_shift_imm = (funct == 6'b000000) || (funct == 6'b000010) ||
                       (funct == 6'b000011);

  always_comb begin
    valid_d     = valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    funct_d     = funct_q;
    reg_write_d = reg_write_q;
    src_a_reg_d = src_a_reg_q;
    src_b_reg_d = src_b_reg_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d     = 1'b1;
      op_a_d      = w_shift_imm ? {{(DW-5){1'b0}}, shamt} : rs_data;
      op_b_d      = use_imm ? {{(DW-16){imm[15]}}, imm} : rt_data;
      rs_d        = rs_addr;
      rt_d        = rt_addr;
      rd_d        = rd_addr;
      funct_d     = funct;
      reg_write_d = reg_write;
      src_a_reg_d = !w_shift_imm;
      src_b_reg_d = !use_imm;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: keep the forwarded operands so they outlive their producer.
      op_a_d = alu_in1;
      op_b_d = alu_in2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
      reg_write_q <= 1'b0;
      src_a_reg_q <= 1'b0;
      src_b_reg_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      funct_q     <= funct_d;
      reg_write_q <= reg_write_d;
      src_a_reg_q <= src_a_reg_d;
      src_b_reg_q <= src_b_reg_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// tb_id_ex_operand_stage: scoreboard bench with directed and random stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] rs_data, rt_data, exmem_result, memwb_result;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt, exmem_rd, memwb_rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        use_imm, reg_write, exmem_reg_write, memwb_reg_write;
  logic        out_valid, out_ready;
  logic [31:0] alu_in1, alu_in2;
  logic [5:0]  alu_con;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  id_ex_operand_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .shamt(shamt), .funct(funct), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_con(alu_con),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        rw;
    logic        sa;
    logic        sb;
  } entry_t;

  entry_t q[$];
  int     total  = 0;
  int     passed = 0;
  logic   held   = 1'b0;
  logic   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_fwd(input logic is_reg, input logic [4:0] a,
                                            input logic [31:0] own);
    if (!is_reg || a == 5'd0) return own;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return own;
  endfunction

  function automatic entry_t model_capture();
    entry_t e;
    e.sa    = !(funct == 6'd0 || funct == 6'd2 || funct == 6'd3);
    e.op_a  = e.sa ? rs_data : 32'(shamt);
    e.sb    = !use_imm;
    e.op_b  = use_imm ? {{16{imm[15]}}, imm} : rt_data;
    e.rs    = rs_addr;
    e.rt    = rt_addr;
    e.rd    = rd_addr;
    e.funct = funct;
    e.rw    = reg_write;
    return e;
  endfunction

  // Monitor: compares the presented entry against the queue head every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        entry_t e;
        logic [31:0] a1, a2;
        e  = q[0];
        a1 = model_fwd(e.sa, e.rs, e.op_a);
        a2 = model_fwd(e.sb, e.rt, e.op_b);
        chk("alu_in1", alu_in1, a1);
        chk("alu_in2", alu_in2, a2);
        chk("alu_con", 32'(alu_con), 32'(e.funct));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        chk("in_ready_held", 32'(in_ready), 32'(out_ready));
        if (!reset && !flush) begin
          if (out_ready) void'(q.pop_front());
          else begin
            e.op_a = a1;
            e.op_b = a2;
            q[0]   = e;
          end
        end
      end else begin
        chk("in_ready_empty", 32'(in_ready), 32'd1);
        chk("ex_reg_write_empty", 32'(ex_reg_write), 32'd0);
      end
    end
  end

  task automatic idle();
    flush = 0; reset = 0; in_valid = 0; out_ready = 1;
    rs_data = 0; rt_data = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
    shamt = 0; funct = 0; imm = 0; use_imm = 0; reg_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [5:0] f,
                       input logic [4:0] sh, input logic [15:0] im, input logic ui,
                       input logic rw);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = rsd;
    rt_data = rtd; funct = f; shamt = sh; imm = im; use_imm = ui; reg_write = rw;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  // Push the stimulus outcome into the scoreboard, then advance past the edge.
  task automatic commit();
    logic acc;
    acc = in_valid && (!held || out_ready);
    if (reset || flush) begin
      q.delete();
      held = 0;
    end else if (acc) begin
      q.push_back(model_capture());
      held = 1;
    end else if (held && out_ready) begin
      held = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    to_neg();
    commit();
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;

    // Reset state
    to_neg();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_alu_con", 32'(alu_con), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    commit();

    // Basic accept and present
    instr(5'd1, 5'd2, 5'd3, 32'h5, 32'h3, 6'b100000, 5'd0, 16'h0, 1'b0, 1'b1);
    to_neg();
    commit();
    idle();
    to_neg();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_in1", alu_in1, 32'h5);
    chk("t1_in2", alu_in2, 32'h3);
    chk("t1_con", 32'(alu_con), 32'h20);
    commit();
    to_neg();
    chk("t1_drained", 32'(out_valid), 32'd0);
    commit();

    // Forwarded value survives its producer while the entry is held
    instr(5'd4, 5'd1, 5'd9, 32'h10, 32'h20, 6'b100000, 5'd0, 16'h0, 1'b0, 1'b1);
    to_neg();
    commit();
    idle();
    out_ready = 0;
    instr(5'd2, 5'd2, 5'd2, 32'h77, 32'h77, 6'b100001, 5'd0, 16'h0, 1'b0, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    to_neg();
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_fwd", alu_in1, 32'hAA);
    commit();
    exmem_reg_write = 0; exmem_result = 32'h0;
    to_neg();
    chk("t2_in_ready2", 32'(in_ready), 32'd0);
    chk("t2_kept", alu_in1, 32'hAA);
    commit();
    drain();
    drain();

    // EX/MEM priority over MEM/WB; R0 never forwarded
    instr(5'd0, 5'd7, 5'd8, 32'h99, 32'h44, 6'b100010, 5'd0, 16'h0, 1'b0, 1'b1);
    to_neg();
    commit();
    idle();
    out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd7; memwb_result = 32'h22;
    to_neg();
    chk("t3_prio", alu_in2, 32'h11);
    chk("t3_r0", alu_in1, 32'h99);
    commit();
    exmem_rd = 5'd0; exmem_result = 32'h55; memwb_rd = 5'd0; memwb_result = 32'h66;
    to_neg();
    chk("t3_r0_write", alu_in1, 32'h99);
    chk("t3_kept", alu_in2, 32'h11);
    commit();
    drain();
    drain();

    // Shift-immediate source and immediate sign extension
    instr(5'd3, 5'd5, 5'd6, 32'h1234, 32'h5, 6'b000000, 5'd3, 16'h0, 1'b0, 1'b1);
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hDEAD;
    to_neg();
    commit();
    instr(5'd1, 5'd0, 5'd6, 32'h8, 32'h0, 6'b100000, 5'd0, 16'hFFFE, 1'b1, 1'b1);
    to_neg();
    chk("t4_shamt", alu_in1, 32'h3);
    chk("t4_rt", alu_in2, 32'h5);
    commit();
    instr(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 6'b000011, 5'd31, 16'h8000, 1'b1, 1'b0);
    to_neg();
    chk("t4_imm", alu_in2, 32'hFFFFFFFE);
    commit();
    idle();
    to_neg();
    chk("t4_shamt31", alu_in1, 32'h1F);
    chk("t4_imm8000", alu_in2, 32'hFFFF8000);
    commit();
    drain();

    // Back-to-back throughput, then backpressure
    for (int i = 0; i < 4; i++) begin
      instr(5'(i + 1), 5'(i + 2), 5'(i + 3), 32'(i * 16 + 1), 32'(i * 16 + 2),
            6'b100100, 5'd0, 16'h0, 1'b0, 1'b1);
      to_neg();
      if (i > 0) chk("t5_no_bubble", 32'(out_valid), 32'd1);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      commit();
    end
    out_ready = 0;
    instr(5'd9, 5'd9, 5'd9, 32'hBAD, 32'hBAD, 6'b100101, 5'd0, 16'h0, 1'b0, 1'b0);
    to_neg();
    chk("t5_stall_ready", 32'(in_ready), 32'd0);
    commit();
    to_neg();
    chk("t5_held_in1", alu_in1, 32'h31);
    chk("t5_held_in2", alu_in2, 32'h32);
    commit();
    drain();
    drain();

    // Flush kills the incoming entry
    instr(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 6'b100000, 5'd0, 16'h0, 1'b0, 1'b1);
    flush = 1;
    to_neg();
    chk("t6_flush_ready", 32'(in_ready), 32'd1);
    commit();
    idle();
    to_neg();
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    chk("t6_flush_we", 32'(ex_reg_write), 32'd0);
    commit();

    // Reset mid-hold
    instr(5'd1, 5'd2, 5'd3, 32'hABC, 32'hDEF, 6'b101010, 5'd0, 16'h0, 1'b0, 1'b1);
    to_neg();
    commit();
    idle();
    out_ready = 0;
    to_neg();
    commit();
    reset = 1;
    out_ready = 0;
    to_neg();
    commit();
    idle();
    to_neg();
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_in1", alu_in1, 32'd0);
    chk("t6_rst_in2", alu_in2, 32'd0);
    chk("t6_rst_con", 32'(alu_con), 32'd0);
    chk("t6_rst_rd", 32'(ex_rd), 32'd0);
    chk("t6_rst_we", 32'(ex_reg_write), 32'd0);
    commit();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      in_valid        = ($urandom_range(0, 3) != 0);
      out_ready       = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      reset           = ($urandom_range(0, 63) == 0);
      rs_addr         = 5'($urandom_range(0, 7));
      rt_addr         = 5'($urandom_range(0, 7));
      rd_addr         = 5'($urandom);
      rs_data         = $urandom;
      rt_data         = $urandom;
      shamt           = 5'($urandom);
      funct           = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      imm             = 16'($urandom);
      use_imm         = 1'($urandom);
      reg_write       = 1'($urandom);
      exmem_reg_write = 1'($urandom);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_result    = $urandom;
      to_neg();
      commit();
    end

    idle();
    to_neg();
    mon_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
